clic_irq_arbiter: RTL

Selects the highest-priority pending, enabled interrupt among N_SOURCE CLIC sources and presents it to the hart over a valid/ready handshake. Sits between the register adapter outputs (intctl, ie, ip, le, shv) and the core interrupt port. Handles preemption: it retracts a presented interrupt when a stronger one appears. On acceptance it pulses a clear for edge-triggered pending bits.

---
 rtl/clic_arb_pkg.sv | 34 +++
 rtl/clic_max_tree.sv | 43 ++++
 rtl/clic_irq_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/clic_arb_pkg.sv
// Shared types and helpers for the CLIC interrupt arbiter: FSM states, key sizing, candidate record.
// Pure definitions; no latency, no backpressure.
package clic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        KILL    = 2'd2,
        ACK     = 2'd3
    } arb_state_e;

    // Candidate fields are sized for the largest supported build; the top uses the low bits.
    localparam int CAND_ID_W  = 10;
    localparam int CAND_KEY_W = 24;

    typedef struct packed {
        logic                  valid;
        logic [CAND_ID_W-1:0]  id;
        logic [CAND_KEY_W-1:0] key;
        logic                  shv;
    } cand_t;

    function automatic int key_width(input bit virt_en, input int vsprio_w);
        return virt_en ? (vsprio_w + 8) : 8;
    endfunction

    // Unimplemented low intctl bits read as ones.
    function automatic logic [7:0] mask_intctl(input logic [7:0] intctl, input int bits);
        logic [7:0] fill;
        fill = 8'hFF >> bits;
        return intctl | fill;
    endfunction

endpackage

// File: rtl/clic_max_tree.sv
// Combinational max-with-index tree over N keyed inputs; equal keys resolve to the higher index.
// Zero latency, no backpressure.
module clic_max_tree #(
    parameter int N  = 32,
    parameter int KW = 8
) (
    input  logic [N-1:0]         vld_i,
    input  logic [N*KW-1:0]      key_i,
    output logic                 vld_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic [KW-1:0]        key_o
);
    localparam int IW    = $clog2(N);
    localparam int NODES = 2 * N - 1;

    logic          nvld [NODES];
    logic [KW-1:0] nkey [NODES];
    logic [IW-1:0] nidx [NODES];

    // Heap layout: leaves N-1.. hold sources in ascending order, node i has children 2i+1 / 2i+2.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            nvld[N-1+k] = vld_i[k];
            nkey[N-1+k] = key_i[k*KW +: KW];
            nidx[N-1+k] = IW'(k);
        end
        for (int i = N - 2; i >= 0; i--) begin
            if (nvld[2*i+2] && (!nvld[2*i+1] || (nkey[2*i+2] >= nkey[2*i+1]))) begin
                nkey[i] = nkey[2*i+2];
                nidx[i] = nidx[2*i+2];
            end else begin
                nkey[i] = nkey[2*i+1];
                nidx[i] = nidx[2*i+1];
            end
            nvld[i] = nvld[2*i+1] | nvld[2*i+2];
        end
    end

    assign vld_o = nvld[0];
    assign idx_o = nidx[0];
    assign key_o = nkey[0];

endmodule

// File: rtl/clic_irq_arbiter.sv
// Picks the strongest pending+enabled CLIC source and presents it to the hart with valid/ready, retracting on preemption.
// ip_i -> irq_valid_o is 2 cycles; output fields hold while unaccepted; virtualization under CLIC_ARB_VIRT_EN.
module clic_irq_arbiter
    import clic_arb_pkg::*;
#(
    parameter int N_SOURCE    = 32,
    parameter int INTCTLBITS  = 8,
    parameter int VsidWidth   = 6,
    parameter int VsprioWidth = 8,
    parameter int MAX_VSCTXTS = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_SOURCE-1:0]           ip_i,
    input  logic [N_SOURCE-1:0]           ie_i,
    input  logic [N_SOURCE-1:0]           le_i,
    input  logic [N_SOURCE-1:0]           shv_i,
    input  logic [8*N_SOURCE-1:0]         intctl_i,
    input  logic [7:0]                    thresh_i,
`ifdef CLIC_ARB_VIRT_EN
    input  logic [N_SOURCE-1:0]           intv_i,
    input  logic [VsidWidth*N_SOURCE-1:0] vsid_i,
    input  logic [VsprioWidth*MAX_VSCTXTS-1:0] vsprio_i,
    output logic                          irq_v_o,
    output logic [VsidWidth-1:0]          irq_vsid_o,
`endif
    output logic                          irq_valid_o,
    input  logic                          irq_ready_i,
    output logic [$clog2(N_SOURCE)-1:0]   irq_id_o,
    output logic [7:0]                    irq_level_o,
    output logic                          irq_shv_o,
    output logic                          irq_kill_req_o,
    input  logic                          irq_kill_ack_i,
    output logic [N_SOURCE-1:0]           edge_clr_o
);
`ifdef CLIC_ARB_VIRT_EN
    localparam bit VIRT = 1'b1;
`else
    localparam bit VIRT = 1'b0;
`endif
    localparam int IW = $clog2(N_SOURCE);
    localparam int KW = key_width(VIRT, VsprioWidth);

    if (N_SOURCE < 4 || (1 << IW) != N_SOURCE || IW > CAND_ID_W || KW > CAND_KEY_W ||
        INTCTLBITS > 8 || VsidWidth < 1 || MAX_VSCTXTS < 1) begin : g_bad_cfg
        $error("clic_irq_arbiter: unsupported parameter set");
    end

    logic [7:0]           lvl  [N_SOURCE];
    logic [N_SOURCE-1:0]  elig;
    logic [N_SOURCE*KW-1:0] keys;

`ifdef CLIC_ARB_VIRT_EN
    logic [VsprioWidth-1:0] vprio [N_SOURCE];
    logic [VsidWidth-1:0]   src_vsid;

    always_comb begin
        for (int k = 0; k < N_SOURCE; k++) begin
            src_vsid = vsid_i[k*VsidWidth +: VsidWidth];
            vprio[k] = '1;
            if (intv_i[k] && (int'(src_vsid) < MAX_VSCTXTS)) begin
                vprio[k] = vsprio_i[int'(src_vsid)*VsprioWidth +: VsprioWidth];
            end
        end
    end
`endif

    // Threshold applies to the masked intctl only; the VS priority only orders winners.
    always_comb begin
        for (int k = 0; k < N_SOURCE; k++) begin
            lvl[k]  = mask_intctl(intctl_i[k*8 +: 8], INTCTLBITS);
            elig[k] = ip_i[k] & ie_i[k] & (lvl[k] > thresh_i);
`ifdef CLIC_ARB_VIRT_EN
            keys[k*KW +: KW] = {vprio[k], lvl[k]};
`else
            keys[k*KW +: KW] = lvl[k];
`endif
        end
    end

    logic          tree_vld;
    logic [IW-1:0] tree_idx;
    logic [KW-1:0] tree_key;

    clic_max_tree #(.N(N_SOURCE), .KW(KW)) u_tree (
        .vld_i (elig),
        .key_i (keys),
        .vld_o (tree_vld),
        .idx_o (tree_idx),
        .key_o (tree_key)
    );

    cand_t cand_d, cand_q;

    always_comb begin
        cand_d       = '0;
        cand_d.valid = tree_vld;
        cand_d.id    = CAND_ID_W'(tree_idx);
        cand_d.key   = CAND_KEY_W'(tree_key);
        cand_d.shv   = shv_i[tree_idx];
    end

    arb_state_e    state_d, state_q;
    logic          load;
    logic          kill_cond;
    logic [IW-1:0] pres_id_q;
    logic [KW-1:0] pres_key_q;
    logic          pres_shv_q;
    logic [IW-1:0] cand_id;
    logic [KW-1:0] cand_key;

    assign cand_id   = cand_q.id[IW-1:0];
    assign cand_key  = cand_q.key[KW-1:0];
    assign kill_cond = (cand_q.valid && (cand_key > pres_key_q)) || !elig[pres_id_q];

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_q.valid) begin
                    state_d = PRESENT;
                    load    = 1'b1;
                end
            end
            PRESENT: begin
                if (irq_ready_i) begin
                    state_d = ACK;
                end else if (kill_cond) begin
                    state_d = KILL;
                end
            end
            KILL:    if (irq_kill_ack_i) state_d = IDLE;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            pres_id_q  <= '0;
            pres_key_q <= '0;
            pres_shv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            if (load) begin
                pres_id_q  <= cand_id;
                pres_key_q <= cand_key;
                pres_shv_q <= cand_q.shv;
            end
        end
    end

`ifdef CLIC_ARB_VIRT_EN
    logic                 pres_v_q;
    logic [VsidWidth-1:0] pres_vsid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pres_v_q    <= 1'b0;
            pres_vsid_q <= '0;
        end else if (load) begin
            pres_v_q    <= intv_i[cand_id];
            pres_vsid_q <= vsid_i[int'(cand_id)*VsidWidth +: VsidWidth];
        end
    end

    assign irq_v_o    = pres_v_q;
    assign irq_vsid_o = pres_vsid_q;
`endif

    logic unused_cand_bits;
    assign unused_cand_bits = ^{cand_q.id[CAND_ID_W-1:IW], cand_q.key[CAND_KEY_W-1:KW]};

    assign irq_valid_o    = (state_q == PRESENT);
    assign irq_kill_req_o = (state_q == KILL);
    assign irq_id_o       = pres_id_q;
    assign irq_level_o    = pres_key_q[7:0];
    assign irq_shv_o      = pres_shv_q;
    // Decoded from the state register so a reset during ACK suppresses the pulse at once.
    assign edge_clr_o     = ((state_q == ACK) && le_i[pres_id_q]) ?
                            ({{(N_SOURCE-1){1'b0}}, 1'b1} << pres_id_q) : '0;

endmodule
